// File: rtl/csr_perf_counters_pkg.sv
// csr_perf_counters_pkg: shared CSR addresses, counter indices and HPM event order for the perf-counter bank.
package csr_perf_counters_pkg;
  localparam int FRONTEND_WIDTH = 4;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_H_OFFSET = 12'h080;
  localparam int IDX_CYCLE = 0;
  localparam int IDX_TIME = 1;
  localparam int IDX_INSTRET = 2;
  localparam int IDX_HPM_BASE = 3;
  typedef enum logic [11:0] {
    CSR_MCYCLE       = 12'hB00,
    CSR_MINSTRET     = 12'hB02,
    CSR_MHPMCOUNTER3 = 12'hB03,
    CSR_MCYCLEH      = 12'hB80,
    CSR_MINSTRETH    = 12'hB82,
    CSR_MHPMCOUNTER3H = 12'hB83,
    CSR_CYCLE        = 12'hC00,
    CSR_TIME         = 12'hC01,
    CSR_INSTRET      = 12'hC02,
    CSR_HPMCOUNTER3  = 12'hC03
  } csr_reg_t;
  typedef enum logic [4:0] {
    EV_ICACHE_MISS   = 5'd3,
    EV_DCACHE_MISS   = 5'd4,
    EV_ITLB_MISS     = 5'd5,
    EV_DTLB_MISS     = 5'd6,
    EV_LOAD          = 5'd7,
    EV_STORE         = 5'd8,
    EV_EXCEPTION     = 5'd9,
    EV_EXCEPTION_RET = 5'd10,
    EV_BRANCH        = 5'd11,
    EV_BRANCH_MISS   = 5'd12,
    EV_CALL          = 5'd13,
    EV_RETURN        = 5'd14,
    EV_MSB_FULL      = 5'd15,
    EV_IF_EMPTY      = 5'd16
  } hpm_event_t;
endpackage

// File: rtl/csr_perf_counters_perf_counter.sv
// perf_counter: one counter with inhibit, multi-step increment and split-half CSR write; a write beats the increment.
module perf_counter #(
  parameter int XLEN = 32,
  parameter int CNT_WIDTH = 64,
  parameter int INC_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 inhibit,
  input  logic [INC_WIDTH-1:0] inc,
  input  logic                 we_lo,
  input  logic                 we_hi,
  input  logic [XLEN-1:0]      wdata,
  output logic [CNT_WIDTH-1:0] value
);
  localparam int LW = XLEN < CNT_WIDTH ? XLEN : CNT_WIDTH;
  logic [CNT_WIDTH-1:0] wr_val;
  always_comb begin
    wr_val = value;
    if (we_lo) wr_val[LW-1:0] = wdata[LW-1:0];
    if (we_hi) wr_val[CNT_WIDTH-1:32] = wdata[CNT_WIDTH-33:0];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) value <= '0;
    else value <= (we_lo || we_hi) ? wr_val : inhibit ? value : value + CNT_WIDTH'(inc);
endmodule

// File: rtl/csr_perf_counters.sv
// csr_perf_counters: mcycle/minstret/HPM counter bank behind CSRs B00-B9F, C00-C9F and mcountinhibit.
// Define HPM_COUNTERS_EN to build HPM counters 3..NB_HPM+2; otherwise indices 3..31 read 0.
module csr_perf_counters
  import csr_perf_counters_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CNT_WIDTH = 64,
  parameter int NB_HPM = 14,
  parameter int INC_WIDTH = $clog2(FRONTEND_WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [INC_WIDTH-1:0]        retire_cnt_i,
  input  logic [NB_HPM*INC_WIDTH-1:0] event_cnt_i,
  input  logic                        csr_req_i,
  input  logic                        csr_we_i,
  input  logic [11:0]                 csr_addr_i,
  input  logic [XLEN-1:0]             csr_wdata_i,
  input  logic                        priv_user_i,
  input  logic [31:0]                 mcounteren_i,
  output logic                        csr_rvalid_o,
  output logic [XLEN-1:0]             csr_rdata_o,
  output logic                        csr_illegal_o
);
`ifdef HPM_COUNTERS_EN
  localparam int HPM_LAST = IDX_HPM_BASE + NB_HPM - 1;
  localparam int LAST_IDX = HPM_LAST;
  localparam logic [63:0] HPM_BITS = (64'd1 << (NB_HPM + IDX_HPM_BASE)) - 64'd1;
  localparam logic [31:0] INH_MASK = HPM_BITS[31:0] & ~(32'd1 << IDX_TIME);
`else
  localparam int HPM_LAST = IDX_HPM_BASE - 1;
  localparam int LAST_IDX = 31;
  localparam logic [31:0] INH_MASK = (32'd1 << IDX_CYCLE) | (32'd1 << IDX_INSTRET);
  logic unused_events;
  assign unused_events = ^event_cnt_i;
`endif
  logic [4:0] idx;
  logic is_inh, is_b, is_c, is_h, impl, illegal, wr_ok;
  logic [31:0] inhibit_q;
  logic [CNT_WIDTH-1:0] cnt [32];
  logic [63:0] cur;
  logic [XLEN-1:0] rd_val;
  assign idx = csr_addr_i[4:0];
  assign is_inh = csr_addr_i == CSR_MCOUNTINHIBIT;
  assign is_h = (csr_addr_i & CSR_H_OFFSET) != 12'd0;
  assign is_b = csr_addr_i[11:8] == 4'hB && csr_addr_i[6:5] == 2'b00;
  assign is_c = csr_addr_i[11:8] == 4'hC && csr_addr_i[6:5] == 2'b00;
  assign impl = idx != 5'(IDX_TIME) && {1'b0, idx} <= 6'(LAST_IDX);
  assign illegal = is_inh ? priv_user_i
                 : !(is_b || is_c) || !impl || (is_c && csr_we_i) || (is_h && XLEN == 64)
                   || (is_b && priv_user_i) || (is_c && priv_user_i && !mcounteren_i[idx]);
  assign wr_ok = csr_req_i && csr_we_i && !illegal;
  assign cur = 64'(cnt[idx]);
  assign rd_val = is_inh ? XLEN'(inhibit_q) : is_h ? XLEN'(cur[63:32]) : cur[XLEN-1:0];
  for (genvar i = 0; i < 32; i++) begin : g_cnt
    if (i == IDX_CYCLE || i == IDX_INSTRET || (i >= IDX_HPM_BASE && i <= HPM_LAST)) begin : g_on
      logic [INC_WIDTH-1:0] inc;
      if (i == IDX_CYCLE) begin : g_cyc
        assign inc = INC_WIDTH'(1);
      end else if (i == IDX_INSTRET) begin : g_ret
        assign inc = retire_cnt_i;
      end else begin : g_hpm
        assign inc = event_cnt_i[(i - IDX_HPM_BASE) * INC_WIDTH +: INC_WIDTH];
      end
      perf_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(INC_WIDTH)) u_cnt (
        .clk(clk),
        .reset_n(reset_n),
        .inhibit(inhibit_q[i]),
        .inc(inc),
        .we_lo(wr_ok && is_b && !is_h && idx == 5'(i)),
        .we_hi(wr_ok && is_b && is_h && idx == 5'(i)),
        .wdata(csr_wdata_i),
        .value(cnt[i])
      );
    end else begin : g_off
      assign cnt[i] = '0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) inhibit_q <= '0;
    else if (wr_ok && is_inh) inhibit_q <= csr_wdata_i[31:0] & INH_MASK;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      csr_rvalid_o <= 1'b0;
      csr_illegal_o <= 1'b0;
      csr_rdata_o <= '0;
    end else begin
      csr_rvalid_o <= csr_req_i;
      csr_illegal_o <= csr_req_i && illegal;
      csr_rdata_o <= (csr_req_i && !illegal) ? rd_val : '0;
    end
endmodule

// File: tb/tb_csr_perf_counters.sv
// tb_csr_perf_counters: directed checks of the perf-counter bank, default parameters (XLEN=32, 64-bit counters).
module tb_csr_perf_counters;
  import csr_perf_counters_pkg::*;
  localparam int NB_HPM = 14;
  localparam int INC_WIDTH = $clog2(FRONTEND_WIDTH + 1);
`ifdef HPM_COUNTERS_EN
  localparam bit HPM = 1'b1;
`else
  localparam bit HPM = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [INC_WIDTH-1:0] retire_cnt = '0;
  logic [NB_HPM*INC_WIDTH-1:0] event_cnt = '0;
  logic csr_req = 1'b0;
  logic csr_we = 1'b0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic priv_user = 1'b0;
  logic [31:0] mcounteren = '0;
  logic csr_rvalid, csr_illegal;
  logic [31:0] csr_rdata;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_perf_counters dut (
    .clk(clk),
    .reset_n(reset_n),
    .retire_cnt_i(retire_cnt),
    .event_cnt_i(event_cnt),
    .csr_req_i(csr_req),
    .csr_we_i(csr_we),
    .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata),
    .priv_user_i(priv_user),
    .mcounteren_i(mcounteren),
    .csr_rvalid_o(csr_rvalid),
    .csr_rdata_o(csr_rdata),
    .csr_illegal_o(csr_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: one request cycle, response checked at the following negedge.
  task automatic access(input string tag, input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic user, input logic exp_ill, input logic [31:0] exp_rd);
    csr_req = 1'b1;
    csr_we = we;
    csr_addr = addr;
    csr_wdata = wdata;
    priv_user = user;
    @(negedge clk);
    csr_req = 1'b0;
    csr_we = 1'b0;
    priv_user = 1'b0;
    chk({tag, ".rvalid"}, 64'(csr_rvalid), 64'd1);
    chk({tag, ".illegal"}, 64'(csr_illegal), 64'(exp_ill));
    if (!we || exp_ill) chk({tag, ".rdata"}, 64'(csr_rdata), 64'(exp_rd));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset.rvalid", 64'(csr_rvalid), 64'd0);
    chk("reset.rdata", 64'(csr_rdata), 64'd0);
    chk("reset.illegal", 64'(csr_illegal), 64'd0);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    access("mcycle100", 1'b0, 12'hB00, 32'd0, 1'b0, 1'b0, 32'd100);
    access("mcycleh", 1'b0, 12'hB80, 32'd0, 1'b0, 1'b0, 32'd0);
    retire_cnt = 3'd2;
    repeat (10) @(negedge clk);
    retire_cnt = 3'd0;
    access("minstret20", 1'b0, 12'hB02, 32'd0, 1'b0, 1'b0, 32'd20);
    access("inh_all_wr", 1'b1, 12'h320, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    access("mcycle_wr", 1'b1, 12'hB00, 32'h0000_1234, 1'b0, 1'b0, 32'd0);
    access("mcycle_frozen1", 1'b0, 12'hB00, 32'd0, 1'b0, 1'b0, 32'h1234);
    access("mcycle_frozen2", 1'b0, 12'hB00, 32'd0, 1'b0, 1'b0, 32'h1234);
    access("inh_mask", 1'b0, 12'h320, 32'd0, 1'b0, 1'b0, HPM ? 32'h0001_FFFD : 32'h0000_0005);
    access("inh_ret_wr", 1'b1, 12'h320, 32'h0000_0004, 1'b0, 1'b0, 32'd0);
    access("inh_ret_rd", 1'b0, 12'h320, 32'd0, 1'b0, 1'b0, 32'h4);
    retire_cnt = 3'd2;
    repeat (5) @(negedge clk);
    retire_cnt = 3'd0;
    access("minstret_frozen", 1'b0, 12'hB02, 32'd0, 1'b0, 1'b0, 32'd20);
    access("mcycle_resumed", 1'b0, 12'hB00, 32'd0, 1'b0, 1'b0, 32'h123B);
    access("hpm3_lo_wr", 1'b1, 12'hB03, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    access("hpm3_hi_wr", 1'b1, 12'hB83, 32'd0, 1'b0, 1'b0, 32'd0);
    event_cnt[2:0] = 3'd1;
    @(negedge clk);
    event_cnt = '0;
    access("hpm3_lo_carry", 1'b0, 12'hB03, 32'd0, 1'b0, 1'b0, 32'd0);
    access("hpm3_hi_carry", 1'b0, 12'hB83, 32'd0, 1'b0, 1'b0, HPM ? 32'd1 : 32'd0);
    event_cnt[5:3] = 3'd2;
    access("hpm4_wr_vs_inc", 1'b1, 12'hB04, 32'd5, 1'b0, 1'b0, 32'd0);
    event_cnt = '0;
    access("hpm4_write_wins", 1'b0, 12'hB04, 32'd0, 1'b0, 1'b0, HPM ? 32'd5 : 32'd0);
    access("idx17", 1'b0, 12'hB11, 32'd0, 1'b0, HPM, 32'd0);
    mcounteren = 32'h0;
    access("u_c03_disabled", 1'b0, 12'hC03, 32'd0, 1'b1, 1'b1, 32'd0);
    mcounteren = 32'h8;
    access("u_c03_enabled", 1'b0, 12'hC03, 32'd0, 1'b1, 1'b0, 32'd0);
    access("u_c83_enabled", 1'b0, 12'hC83, 32'd0, 1'b1, 1'b0, HPM ? 32'd1 : 32'd0);
    access("u_c04_disabled", 1'b0, 12'hC04, 32'd0, 1'b1, 1'b1, 32'd0);
    access("u_c83_write", 1'b1, 12'hC83, 32'h55, 1'b1, 1'b1, 32'd0);
    access("m_c03_write", 1'b1, 12'hC03, 32'h55, 1'b0, 1'b1, 32'd0);
    access("hpm3_unchanged", 1'b0, 12'hB83, 32'd0, 1'b0, 1'b0, HPM ? 32'd1 : 32'd0);
    access("u_b00", 1'b0, 12'hB00, 32'd0, 1'b1, 1'b1, 32'd0);
    @(negedge clk);
    chk("rvalid_pulse", 64'(csr_rvalid), 64'd0);
    csr_req = 1'b1;
    csr_we = 1'b0;
    csr_addr = 12'hB00;
    @(posedge clk);
    #1;
    chk("pre_reset.rvalid", 64'(csr_rvalid), 64'd1);
    chk("pre_reset.nonzero", 64'(csr_rdata != 32'd0), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("async_reset.rvalid", 64'(csr_rvalid), 64'd0);
    chk("async_reset.rdata", 64'(csr_rdata), 64'd0);
    chk("async_reset.illegal", 64'(csr_illegal), 64'd0);
    csr_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    access("mcycle_restart0", 1'b0, 12'hB00, 32'd0, 1'b0, 1'b0, 32'd0);
    access("mcycle_restart1", 1'b0, 12'hB00, 32'd0, 1'b0, 1'b0, 32'd1);
    access("minstret_reset", 1'b0, 12'hB02, 32'd0, 1'b0, 1'b0, 32'd0);
    access("inh_reset", 1'b0, 12'h320, 32'd0, 1'b0, 1'b0, 32'd0);
    access("time_c01", 1'b0, 12'hC01, 32'd0, 1'b0, 1'b1, 32'd0);
    access("time_b01", 1'b0, 12'hB01, 32'd0, 1'b0, 1'b1, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
